// File: rtl/event_write_scheduler.sv
// event_write_scheduler
// Queues trigger pulses and, when the shared ring has room, writes one event
// (HALF_PACKAGE_LENGTH samples per input) through a common wen/waddr bus.
// When the write finishes it pulses w_complete for every enabled input and
// advances the ring write base.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a queued trigger and free ring space
// S_WRITE | wen high, waddr walking the ring from base
// S_DONE  | one-cycle w_complete pulse, base/n_written advance on exit
module event_write_scheduler #(
    parameter int N_INPUT        = 16,
    parameter int MAX_TRIG_QUEUE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               live_rising,
    input  logic               trigger,
    input  logic [9:0]         HALF_PACKAGE_LENGTH,
    input  logic [13:0]        MEMORY_DEPTH,
    input  logic [4:0]         MAX_NEVENT,
    input  logic [N_INPUT-1:0] input_ena,
    input  logic [15:0]        n_read,
    output logic               wen,
    output logic [13:0]        waddr,
    output logic [N_INPUT-1:0] w_complete,
    output logic [15:0]        n_written,
    output logic [2:0]         trig_pending,
    output logic               busy,
    output logic               trig_overflow,
    output logic               cfg_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2:0] QMAX = 3'(MAX_TRIG_QUEUE);

    logic [1:0]         state;
    logic [13:0]        base;
    logic [9:0]         cnt;
    logic [N_INPUT-1:0] ena_l;

    logic [15:0] occupancy;
    logic        cfg_bad;
    logic        ena_zero;
    logic        space_ok;
    logic        deq;
    logic        start;
    logic [14:0] base_sum;
    logic [14:0] base_wrap;

    // Admission decision: a queued trigger is consumed when it can start, or
    // when it must be discarded (bad config / nothing enabled). It is held
    // only while the ring is full.
    always_comb begin
        occupancy = n_written - n_read;
        cfg_bad   = (HALF_PACKAGE_LENGTH == 10'd0) || (MEMORY_DEPTH == 14'd0) ||
                    ({4'd0, HALF_PACKAGE_LENGTH} > MEMORY_DEPTH);
        ena_zero  = (input_ena == '0);
        space_ok  = (occupancy < {11'd0, MAX_NEVENT});
        deq       = (state == S_IDLE) && (trig_pending != 3'd0) &&
                    (cfg_bad || ena_zero || space_ok);
        start     = deq && !cfg_bad && !ena_zero;
        base_sum  = {1'b0, base} + {5'd0, HALF_PACKAGE_LENGTH};
        base_wrap = (base_sum >= {1'b0, MEMORY_DEPTH}) ? (base_sum - {1'b0, MEMORY_DEPTH})
                                                       : base_sum;
    end

    assign busy = (state != S_IDLE);

    // Trigger queue and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_pending  <= 3'd0;
            trig_overflow <= 1'b0;
            cfg_err       <= 1'b0;
        end else if (live_rising) begin
            trig_pending  <= 3'd0;
            trig_overflow <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            if (trigger && !deq) begin
                if (trig_pending == QMAX)
                    trig_overflow <= 1'b1;
                else
                    trig_pending <= trig_pending + 3'd1;
            end else if (deq && !trigger) begin
                trig_pending <= trig_pending - 3'd1;
            end
            if (deq && cfg_bad)
                cfg_err <= 1'b1;
        end
    end

    // Write sequencer: address walk, completion pulse and ring base advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            base       <= 14'd0;
            cnt        <= 10'd0;
            ena_l      <= '0;
            wen        <= 1'b0;
            waddr      <= 14'd0;
            w_complete <= '0;
            n_written  <= 16'd0;
        end else if (live_rising) begin
            state      <= S_IDLE;
            base       <= 14'd0;
            cnt        <= 10'd0;
            ena_l      <= '0;
            wen        <= 1'b0;
            waddr      <= 14'd0;
            w_complete <= '0;
            n_written  <= 16'd0;
        end else begin
            w_complete <= '0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ena_l <= input_ena;
                        wen   <= 1'b1;
                        waddr <= base;
                        cnt   <= 10'd0;
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (cnt == HALF_PACKAGE_LENGTH - 10'd1) begin
                        wen        <= 1'b0;
                        w_complete <= ena_l;
                        state      <= S_DONE;
                    end else begin
                        cnt   <= cnt + 10'd1;
                        waddr <= (waddr == MEMORY_DEPTH - 14'd1) ? 14'd0 : waddr + 14'd1;
                    end
                end
                S_DONE: begin
                    n_written <= n_written + 16'd1;
                    base      <= base_wrap[13:0];
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_event_write_scheduler.sv
// Directed bench for event_write_scheduler.
module tb_event_write_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        live_rising = 1'b0;
    logic        trigger = 1'b0;
    logic [9:0]  hpl = 10'd4;
    logic [13:0] depth = 14'd16;
    logic [4:0]  max_nevent = 5'd31;
    logic [15:0] input_ena = 16'hFFFF;
    logic [15:0] n_read = 16'd0;
    logic        wen;
    logic [13:0] waddr;
    logic [15:0] w_complete;
    logic [15:0] n_written;
    logic [2:0]  trig_pending;
    logic        busy;
    logic        trig_overflow;
    logic        cfg_err;

    int errors = 0;
    int checks = 0;

    event_write_scheduler #(.N_INPUT(16), .MAX_TRIG_QUEUE(4)) dut (
        .clk(clk), .rst(rst), .live_rising(live_rising), .trigger(trigger),
        .HALF_PACKAGE_LENGTH(hpl), .MEMORY_DEPTH(depth), .MAX_NEVENT(max_nevent),
        .input_ena(input_ena), .n_read(n_read), .wen(wen), .waddr(waddr),
        .w_complete(w_complete), .n_written(n_written), .trig_pending(trig_pending),
        .busy(busy), .trig_overflow(trig_overflow), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fire();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
    endtask

    task automatic clear_run();
        live_rising = 1'b1;
        tick();
        live_rising = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (!busy && trig_pending == 3'd0) break;
            tick();
        end
        chk(tag, {31'd0, busy} | {29'd0, trig_pending}, 32'd0);
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_wen", wen, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_nw", n_written, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {trig_overflow, cfg_err, trig_pending}, 0);
        tick();
        rst = 1'b0;
        tick();

        // 1: HPL=4, DEPTH=16, basic latency
        fire();                                   // now T+1
        chk("t1_pend", trig_pending, 1);
        chk("t1_wen_T1", wen, 0);
        for (int i = 0; i < 4; i++) begin
            tick();                               // T+2 .. T+5
            chk("t1_wen", wen, 1);
            chk("t1_waddr", waddr, i);
            chk("t1_wc_low", w_complete, 0);
        end
        tick();                                   // T+6
        chk("t1_wen_off", wen, 0);
        chk("t1_wc", w_complete, 16'hFFFF);
        chk("t1_busy_done", busy, 1);
        tick();                                   // T+7
        chk("t1_wc_clr", w_complete, 0);
        chk("t1_nw", n_written, 1);
        chk("t1_busy", busy, 0);

        // 2: base reaches 14 in DEPTH=21, then HPL=10 wraps
        clear_run();
        chk("t2_clear_nw", n_written, 0);
        depth = 14'd21;
        hpl = 10'd7;
        fire();
        wait_idle("t2_idle_a");
        fire();
        wait_idle("t2_idle_b");
        chk("t2_nw2", n_written, 2);
        hpl = 10'd10;
        fire();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_wen", wen, 1);
            chk("t2_waddr", waddr, (14 + i) % 21);
        end
        tick();
        chk("t2_wen_off", wen, 0);
        chk("t2_wc", w_complete, 16'hFFFF);
        tick();
        chk("t2_nw3", n_written, 3);
        hpl = 10'd2;
        fire();
        tick();
        chk("t2_base3_wen", wen, 1);
        chk("t2_base3", waddr, 3);
        wait_idle("t2_idle_c");
        chk("t2_nw4", n_written, 4);

        // 3: ring full holds the third trigger
        clear_run();
        depth = 14'd16;
        hpl = 10'd4;
        max_nevent = 5'd2;
        input_ena = 16'h00A5;
        trigger = 1'b1;
        tick();
        tick();
        tick();
        trigger = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        chk("t3_nw", n_written, 2);
        chk("t3_pend", trig_pending, 1);
        chk("t3_busy", busy, 0);
        chk("t3_wen", wen, 0);
        chk("t3_ovf", trig_overflow, 0);
        n_read = 16'd1;
        tick();
        chk("t3_start_wen", wen, 1);
        chk("t3_start_addr", waddr, 8);
        chk("t3_pend0", trig_pending, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("t3_wc", w_complete, 16'h00A5);
        wait_idle("t3_idle");
        chk("t3_nw3", n_written, 3);

        // 4: queue saturation while busy
        clear_run();
        n_read = 16'd0;
        max_nevent = 5'd31;
        input_ena = 16'hFFFF;
        hpl = 10'd16;
        fire();
        tick();
        chk("t4_busy", busy, 1);
        trigger = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        trigger = 1'b0;
        chk("t4_pend", trig_pending, 4);
        chk("t4_ovf", trig_overflow, 1);

        // 5: live_rising aborts a write at cnt=2
        clear_run();
        chk("t5_clear_ovf", trig_overflow, 0);
        hpl = 10'd8;
        fire();
        tick();
        tick();
        tick();
        chk("t5_cnt2_addr", waddr, 2);
        chk("t5_cnt2_wen", wen, 1);
        live_rising = 1'b1;
        tick();
        live_rising = 1'b0;
        chk("t5_wen", wen, 0);
        chk("t5_waddr", waddr, 0);
        chk("t5_busy", busy, 0);
        chk("t5_nw", n_written, 0);
        chk("t5_pend", trig_pending, 0);
        begin
            logic seen_wc;
            seen_wc = 1'b0;
            for (int i = 0; i < 12; i++) begin
                if (w_complete != 16'd0 || wen) seen_wc = 1'b1;
                tick();
            end
            chk("t5_no_wc", seen_wc, 0);
        end

        // 6: bad config, empty enable, async reset
        hpl = 10'd0;
        fire();
        tick();
        chk("t6_cfg_err", cfg_err, 1);
        chk("t6_pend", trig_pending, 0);
        chk("t6_wen", wen, 0);
        chk("t6_busy", busy, 0);
        hpl = 10'd20;
        fire();
        tick();
        chk("t6_hpl_gt_depth_wen", wen, 0);
        hpl = 10'd4;
        input_ena = 16'd0;
        fire();
        tick();
        chk("t6_ena0_pend", trig_pending, 0);
        chk("t6_ena0_wen", wen, 0);
        tick();
        tick();
        chk("t6_ena0_nw", n_written, 0);
        chk("t6_ena0_wc", w_complete, 0);
        input_ena = 16'hFFFF;
        fire();
        tick();
        chk("t6_pre_rst_wen", wen, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_arst_wen", wen, 0);
        chk("t6_arst_busy", busy, 0);
        chk("t6_arst_flags", {trig_overflow, cfg_err, trig_pending}, 0);
        tick();
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
